// File: rtl/so_ml_search.sv
// Maximum-likelihood search over a 16-entry spatial-modulation codebook.
// Holds one received 8-element complex vector and walks every codebook entry
// once per search (256 cycles), accumulating squared Euclidean distance per
// candidate and reporting the closest one. Ties resolve to the lower index.
module so_ml_search #(
  parameter int unsigned W   = 8,
  parameter int unsigned AMP = 64,
  localparam int unsigned MW = 2*(W+2)+4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [16*W-1:0] y_in,
  output logic [3:0]      cb_cand,
  output logic            cb_re,
  output logic [2:0]      cb_elem,
  input  logic [1:0]      cb_data,
  output logic            busy,
  output logic            done,
  output logic [3:0]      best_idx,
  output logic [MW-1:0]   best_metric
);

  localparam int unsigned PW = 2*(W+2);
  localparam logic signed [W+1:0] AmpS = (W+2)'(AMP);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [MW-1:0]     acc_q, acc_d;
  logic [MW-1:0]     best_int_q, best_int_d;
  logic [3:0]        best_idx_int_q, best_idx_int_d;
  logic [16*W-1:0]   y_q, y_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        best_idx_q, best_idx_d;
  logic [MW-1:0]     best_metric_q, best_metric_d;

  logic [3:0]            y_word;
  logic [W-1:0]          y_sel;
  logic signed [W+1:0]   cb_val;
  logic signed [W+1:0]   diff;
  logic signed [PW-1:0]  sq;
  logic [PW-1:0]         term;
  logic [MW-1:0]         m;
  logic                  better;

  // Address ports follow the counter only while searching.
  assign cb_cand = (state_q == StRun) ? cnt_q[7:4] : 4'd0;
  assign cb_elem = (state_q == StRun) ? cnt_q[3:1] : 3'd0;
  assign cb_re   = (state_q == StRun) ? ~cnt_q[0]  : 1'b0;

  assign busy        = busy_q;
  assign done        = done_q;
  assign best_idx    = best_idx_q;
  assign best_metric = best_metric_q;

  // Datapath: distance term for the entry currently addressed.
  always_comb begin
    // Word 2e+1 is the real part of element e, word 2e the imaginary part.
    y_word = {cnt_q[3:1], ~cnt_q[0]};
    y_sel  = y_q[32'(y_word) * W +: W];
    case (cb_data)
      2'b01:   cb_val = AmpS;
      2'b11:   cb_val = -AmpS;
      default: cb_val = '0;  // 2'b10 is illegal and treated as zero
    endcase
    diff   = $signed({{2{y_sel[W-1]}}, y_sel}) - cb_val;
    sq     = diff * diff;
    term   = sq;
    m      = acc_q + {{(MW-PW){1'b0}}, term};
    better = (m < best_int_q);
  end

  // Next-state logic for the search sequencer.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    best_int_d     = best_int_q;
    best_idx_int_d = best_idx_int_q;
    y_d            = y_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    best_idx_d     = best_idx_q;
    best_metric_d  = best_metric_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          y_d            = y_in;
          cnt_d          = '0;
          acc_d          = '0;
          best_int_d     = '1;
          best_idx_int_d = '0;
          busy_d         = 1'b1;
          state_d        = StRun;
        end
      end
      StRun: begin
        if (cnt_q[3:0] == 4'hF) begin
          if (better) begin
            best_int_d     = m;
            best_idx_int_d = cnt_q[7:4];
          end
          acc_d = '0;
        end else begin
          acc_d = m;
        end
        if (cnt_q == 8'hFF) begin
          best_idx_d    = better ? cnt_q[7:4] : best_idx_int_q;
          best_metric_d = better ? m : best_int_q;
          done_d        = 1'b1;
          state_d       = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; asynchronous reset aborts any search in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      acc_q          <= '0;
      best_int_q     <= '0;
      best_idx_int_q <= '0;
      y_q            <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      best_idx_q     <= '0;
      best_metric_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      best_int_q     <= best_int_d;
      best_idx_int_q <= best_idx_int_d;
      y_q            <= y_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      best_idx_q     <= best_idx_d;
      best_metric_q  <= best_metric_d;
    end
  end

endmodule

// File: tb/tb_so_ml_search.sv
// Scoreboard bench for so_ml_search: stimulus pushes expected results from a
// plain argmin reference model; a negedge monitor pops and compares on done.
module tb_so_ml_search;

  localparam int W   = 8;
  localparam int AMP = 64;
  localparam int MW  = 2*(W+2)+4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [16*W-1:0] y_in;
  logic [3:0]      cb_cand;
  logic            cb_re;
  logic [2:0]      cb_elem;
  logic [1:0]      cb_data;
  logic            busy;
  logic            done;
  logic [3:0]      best_idx;
  logic [MW-1:0]   best_metric;

  // Codebook model: [candidate][1 = real, 0 = imag][element]
  logic [1:0] cb_mem [16][2][8];
  assign cb_data = cb_mem[cb_cand][cb_re][cb_elem];

  typedef struct {
    int     idx;
    longint met;
    longint t0;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  longint cyc;
  int     n_vec;
  int     n_miss;

  so_ml_search #(.W(W), .AMP(AMP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .y_in        (y_in),
    .cb_cand     (cb_cand),
    .cb_re       (cb_re),
    .cb_elem     (cb_elem),
    .cb_data     (cb_data),
    .busy        (busy),
    .done        (done),
    .best_idx    (best_idx),
    .best_metric (best_metric)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dec(input logic [1:0] c);
    if (c == 2'b01) return AMP;
    if (c == 2'b11) return -AMP;
    return 0;
  endfunction

  function automatic int y_part(input logic [16*W-1:0] y, input int e, input bit re);
    logic signed [W-1:0] s;
    s = re ? y[(2*e+1)*W +: W] : y[2*e*W +: W];
    return int'(s);
  endfunction

  function automatic longint cand_metric(input logic [16*W-1:0] y, input int k);
    longint sum;
    longint dr;
    longint di;
    sum = 0;
    for (int e = 0; e < 8; e++) begin
      dr = y_part(y, e, 1'b1) - dec(cb_mem[k][1][e]);
      di = y_part(y, e, 1'b0) - dec(cb_mem[k][0][e]);
      sum += dr*dr + di*di;
    end
    return sum;
  endfunction

  // First minimum wins, so ties go to the lowest candidate index.
  task automatic ref_search(input logic [16*W-1:0] y, output int bi, output longint bm);
    longint mk;
    bi = 0;
    bm = cand_metric(y, 0);
    for (int k = 1; k < 16; k++) begin
      mk = cand_metric(y, k);
      if (mk < bm) begin
        bi = k;
        bm = mk;
      end
    end
  endtask

  function automatic logic [16*W-1:0] pack_elem(input logic [16*W-1:0] y, input int e,
                                                input int re, input int im);
    logic [16*W-1:0] r;
    r = y;
    r[(2*e+1)*W +: W] = re[W-1:0];
    r[2*e*W +: W]     = im[W-1:0];
    return r;
  endfunction

  // Received vector equal to AMP times candidate k, plus optional bounded noise.
  function automatic logic [16*W-1:0] y_from_cand(input int k, input int noise);
    logic [16*W-1:0] y;
    int re;
    int im;
    y = '0;
    for (int e = 0; e < 8; e++) begin
      re = dec(cb_mem[k][1][e]);
      im = dec(cb_mem[k][0][e]);
      if (noise > 0) begin
        re += int'($urandom_range(0, 2*noise)) - noise;
        im += int'($urandom_range(0, 2*noise)) - noise;
      end
      y = pack_elem(y, e, re, im);
    end
    return y;
  endfunction

  function automatic logic [16*W-1:0] y_random();
    logic [16*W-1:0] y;
    for (int i = 0; i < 4; i++) y[32*i +: 32] = $urandom;
    return y;
  endfunction

  task automatic start_search(input logic [16*W-1:0] y);
    exp_t   e;
    int     bi;
    longint bm;
    y_in  = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ref_search(y, bi, bm);
    e.idx = bi;
    e.met = bm;
    e.t0  = cyc;
    sb_q.push_back(e);
    chk("busy_rise", longint'(busy), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_timeout: got no done, expected done within 256 cycles");
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_best_idx"}, longint'(best_idx), 0);
    chk({tag, "_best_metric"}, longint'(best_metric), 0);
    chk({tag, "_cb_cand"}, longint'(cb_cand), 0);
    chk({tag, "_cb_re"}, longint'(cb_re), 0);
    chk({tag, "_cb_elem"}, longint'(cb_elem), 0);
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("best_idx", longint'(best_idx), mon_e.idx);
        chk("best_metric", longint'(best_metric), mon_e.met);
        chk("latency", cyc - mon_e.t0, 256);
      end
    end
  end

  initial begin
    int n;
    int e;
    logic [16*W-1:0] y;
    n_vec  = 0;
    n_miss = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    y_in   = '0;

    // Candidate 0, candidate 15, the rest random with one nonzero part per element.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 8; i++) begin
        cb_mem[k][1][i] = 2'b00;
        cb_mem[k][0][i] = 2'b00;
        if (k != 0 && k != 15)
          cb_mem[k][$urandom_range(0, 1)][i] = $urandom_range(0, 1) ? 2'b01 : 2'b11;
      end
    end
    for (int i = 0; i < 8; i++) cb_mem[0][1][i] = (i == 2 || i == 6) ? 2'b11 : 2'b01;
    for (int i = 0; i < 4; i++) cb_mem[15][1][i] = (i == 2) ? 2'b11 : 2'b01;
    for (int i = 4; i < 8; i++) cb_mem[15][0][i] = 2'b11;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    start_search(y_from_cand(0, 0));
    wait_idle();
    chk("cand0_idx", longint'(best_idx), 0);
    chk("cand0_metric", longint'(best_metric), 0);

    start_search(y_from_cand(15, 0));
    wait_idle();
    chk("cand15_idx", longint'(best_idx), 15);
    chk("cand15_metric", longint'(best_metric), 0);

    start_search('0);
    wait_idle();
    chk("zero_idx", longint'(best_idx), 0);
    chk("zero_metric", longint'(best_metric), 8*AMP*AMP);

    y = '0;
    for (int i = 0; i < 8; i++) y = pack_elem(y, i, 127, -128);
    start_search(y);
    wait_idle();

    // Starts at E100 and in the DONE cycle are ignored; a start at E258 is taken.
    start_search(y_from_cand(5, 10));
    repeat (99) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    y_in  = y_random();
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 300);
    chk("done_seen", longint'(done), 1);
    start = 1'b1;
    y_in  = y_random();
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_fall", longint'(done), 0);
    chk("busy_fall", longint'(busy), 0);
    start_search(y_from_cand(9, 8));
    wait_idle();

    // Reset at E50 aborts the search with no done.
    start_search(y_from_cand(3, 5));
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    start_search(y_from_cand(3, 5));
    wait_idle();

    for (int r = 0; r < 12; r++) begin
      if (r % 2 == 0) start_search(y_random());
      else start_search(y_from_cand(int'($urandom_range(0, 15)), 24));
      wait_idle();
    end

    // Illegal 2'b10 entries must decode to zero.
    for (int i = 0; i < 12; i++) begin
      e = int'($urandom_range(0, 7));
      cb_mem[$urandom_range(1, 14)][$urandom_range(0, 1)][e] = 2'b10;
    end
    for (int r = 0; r < 4; r++) begin
      start_search(y_from_cand(int'($urandom_range(1, 14)), 16));
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
